// File: rtl/fifo_rdout_sched.sv
// Event readout scheduler: visits each flagged FIFO in ascending order, reads it
// until its end-of-frame word or a watchdog timeout, then reports completion.

module sched_cnt #(
   parameter int W   = 12,
   parameter int TMR = 0
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam int NCOPY = (TMR != 0) ? 3 : 1;

   logic [NCOPY-1:0][W-1:0] copy_q;
   logic [W-1:0]            voted;
   logic [W-1:0]            cnt_next;

   // Every copy reloads from the voted value, so a single upset heals in one cycle.
   always_comb begin
      cnt_next = voted;
      if (clr) begin
         cnt_next = '0;
      end else if (inc && (voted != {W{1'b1}})) begin
         cnt_next = voted + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCOPY; gi++) begin : g_copy
         logic [W-1:0] cnt_reg;
         always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_next;
            end
         end
         assign copy_q[gi] = cnt_reg;
      end

      if (NCOPY == 3) begin : g_vote
         assign voted = (copy_q[0] & copy_q[1]) |
                        (copy_q[0] & copy_q[2]) |
                        (copy_q[1] & copy_q[2]);
      end else begin : g_single
         assign voted = copy_q[0];
      end
   endgenerate

   assign q = voted;

endmodule

module fifo_rdout_sched #(
   parameter int TMR  = 0,
   parameter int TOUT = 4095
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        start,
   input  logic [7:1]  davenbl,
   input  logic [7:1]  ffor_b,
   input  logic        rdffnxt,
   input  logic        eof_det,
   output logic [7:1]  renfifo_b,
   output logic [7:1]  oefifo_b,
   output logic [2:0]  sel,
   output logic        busy,
   output logic        pop,
   output logic [7:1]  toerr,
   output logic [15:0] wrdcnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SCAN,
      ST_OE_SETUP,
      ST_READ,
      ST_GAP,
      ST_DONE
   } state_t;

   localparam logic [11:0] TOUT_LAST = 12'(TOUT - 1);

   state_t      state_reg, state_next;
   logic [7:1]  pend_reg, pend_next;
   logic [2:0]  sel_reg, sel_next;
   logic [7:1]  oe_reg, oe_next;
   logic [7:1]  ren_reg, ren_next;
   logic        busy_reg, busy_next;
   logic        pop_reg, pop_next;
   logic [7:1]  toerr_reg, toerr_next;

   logic [2:0]  low_idx;
   logic [7:1]  low_onehot;
   logic [7:1]  sel_onehot;
   logic        read_ok;
   logic [11:0] wd_q;
   logic        wd_clr, wd_inc;
   logic        wrd_clr, wrd_inc;

   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 1; i--) begin
         if (pend_reg[i]) begin
            low_idx = 3'(i);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi <= 7; gi++) begin : g_dec
         assign low_onehot[gi] = (low_idx == 3'(gi));
         assign sel_onehot[gi] = (sel_reg == 3'(gi));
      end
   endgenerate

   // RDFFNXT/FFOR_B sampled now decide the registered read strobe of the next cycle.
   assign read_ok = rdffnxt && ((sel_onehot & ~ffor_b) != 7'h00);

   assign wd_clr  = (state_reg == ST_OE_SETUP);
   assign wd_inc  = (state_reg == ST_READ);
   assign wrd_inc = (state_reg == ST_READ) && (ren_reg != 7'h7F);

   sched_cnt #(.W(12), .TMR(TMR)) u_wdog (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (wd_clr),
      .inc   (wd_inc),
      .q     (wd_q)
   );

   sched_cnt #(.W(16), .TMR(TMR)) u_wrdcnt (
      .clk   (clk),
      .rst_b (rst_b),
      .clr   (wrd_clr),
      .inc   (wrd_inc),
      .q     (wrdcnt)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg <= ST_IDLE;
         pend_reg  <= '0;
         sel_reg   <= '0;
         oe_reg    <= 7'h7F;
         ren_reg   <= 7'h7F;
         busy_reg  <= 1'b0;
         pop_reg   <= 1'b0;
         toerr_reg <= '0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
         sel_reg   <= sel_next;
         oe_reg    <= oe_next;
         ren_reg   <= ren_next;
         busy_reg  <= busy_next;
         pop_reg   <= pop_next;
         toerr_reg <= toerr_next;
      end
   end

   // Outputs are computed for the state being entered so they appear registered.
   always_comb begin
      state_next = state_reg;
      pend_next  = pend_reg;
      sel_next   = sel_reg;
      oe_next    = 7'h7F;
      ren_next   = 7'h7F;
      busy_next  = busy_reg;
      pop_next   = 1'b0;
      toerr_next = toerr_reg;
      wrd_clr    = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SCAN;
               pend_next  = davenbl;
               busy_next  = 1'b1;
               toerr_next = '0;
               wrd_clr    = 1'b1;
            end
         end
         ST_SCAN: begin
            if (pend_reg == 7'h00) begin
               state_next = ST_DONE;
               pop_next   = 1'b1;
            end else begin
               state_next = ST_OE_SETUP;
               sel_next   = low_idx;
               pend_next  = pend_reg & ~low_onehot;
               oe_next    = ~low_onehot;
            end
         end
         ST_OE_SETUP: begin
            state_next = ST_READ;
            oe_next    = ~sel_onehot;
            if (read_ok) begin
               ren_next = ~sel_onehot;
            end
         end
         ST_READ: begin
            if (eof_det) begin
               state_next = ST_GAP;
               sel_next   = '0;
            end else if (wd_q >= TOUT_LAST) begin
               state_next = ST_GAP;
               sel_next   = '0;
               toerr_next = toerr_reg | sel_onehot;
            end else begin
               oe_next = ~sel_onehot;
               if (read_ok) begin
                  ren_next = ~sel_onehot;
               end
            end
         end
         ST_GAP: begin
            state_next = ST_SCAN;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            busy_next  = 1'b0;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign renfifo_b = ren_reg;
   assign oefifo_b  = oe_reg;
   assign sel       = sel_reg;
   assign busy      = busy_reg;
   assign pop       = pop_reg;
   assign toerr     = toerr_reg;

endmodule

// File: tb/tb_fifo_rdout_sched.sv
// Randomized scoreboard bench for fifo_rdout_sched: the bench plays the FIFOs and
// the downstream consumer, and predicts each event's outcome from the FIFO setup.

module tb_fifo_rdout_sched;

   localparam int TOUT = 16;

   typedef struct packed {
      logic [7:1]  toerr;
      logic [15:0] wrd;
      logic [7:1]  mask;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        start;
   logic [7:1]  davenbl;
   logic [7:1]  ffor_b;
   logic        rdffnxt;
   logic        eof_det;
   logic [7:1]  renfifo_b;
   logic [7:1]  oefifo_b;
   logic [2:0]  sel;
   logic        busy;
   logic        pop;
   logic [7:1]  toerr;
   logic [15:0] wrdcnt;

   always #5 clk = ~clk;

   fifo_rdout_sched #(.TMR(1), .TOUT(TOUT)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .davenbl   (davenbl),
      .ffor_b    (ffor_b),
      .rdffnxt   (rdffnxt),
      .eof_det   (eof_det),
      .renfifo_b (renfifo_b),
      .oefifo_b  (oefifo_b),
      .sel       (sel),
      .busy      (busy),
      .pop       (pop),
      .toerr     (toerr),
      .wrdcnt    (wrdcnt)
   );

   // kind: 0 = normal FIFO ending with EOF after words[j] reads,
   //       1 = output never ready (timeout), 2 = never ready but EOF in the last watchdog cycle
   int          kind  [1:7];
   int          words [1:7];
   int          rd_mode;
   exp_t        exp_q [$];
   int          n_chk = 0;
   int          n_pass = 0;
   bit          done = 1'b0;
   logic [15:0] last_wrd = '0;
   logic [7:1]  last_toerr = '0;

   logic [7:1]  cur, prv, vmask, sel_oh;
   int          cur_k, cyc, rd, visits;
   bit          order_ok, last_rdf, inv_ok;
   exp_t        e_mon;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t model(input logic [7:1] dav);
      exp_t e;
      e = '0;
      e.mask = dav;
      for (int j = 1; j <= 7; j++) begin
         if (dav[j]) begin
            if (kind[j] == 0) begin
               e.wrd = e.wrd + 16'(words[j]);
            end else if (kind[j] == 1) begin
               e.toerr[j] = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic set_all(input int k, input int w);
      for (int j = 1; j <= 7; j++) begin
         kind[j]  = k;
         words[j] = w;
      end
   endtask

   // Called just after a rising edge; raising START here makes the next edge accept it.
   task automatic run_event(input logic [7:1] dav, input int mode, input bit extra);
      exp_t       e;
      logic [7:1] eoe;
      int         n;
      check("hold_wrdcnt", 32'(wrdcnt), 32'(last_wrd));
      check("hold_toerr", 32'(toerr), 32'(last_toerr));
      check("idle_busy", 32'(busy), 32'd0);
      e = model(dav);
      rd_mode = mode;
      for (int j = 1; j <= 7; j++) ffor_b[j] = (kind[j] != 0);
      eoe = 7'h7F;
      for (int j = 7; j >= 1; j--) if (dav[j]) eoe = 7'h7F & ~(7'h01 << (j - 1));
      start   = 1'b1;
      davenbl = dav;
      exp_q.push_back(e);
      @(posedge clk); #1;
      start   = extra;
      davenbl = 7'($urandom);
      check("busy_after_start", 32'(busy), 32'd1);
      @(posedge clk); #1;
      start   = 1'b0;
      davenbl = 7'($urandom);
      if (dav == 7'h00) check("empty_pop_latency", 32'(pop), 32'd1);
      else              check("first_oe_latency", 32'(oefifo_b), 32'(eoe));
      n = 0;
      while (busy && n < 800) begin
         @(posedge clk); #1;
         n++;
      end
      check("done_in_time", 32'(busy), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      last_wrd   = e.wrd;
      last_toerr = e.toerr;
   endtask

   initial begin
      rst_b   = 1'b0;
      start   = 1'b0;
      davenbl = '0;
      ffor_b  = '0;
      rdffnxt = 1'b0;
      eof_det = 1'b0;
      rd_mode = 0;
      set_all(0, 1);
      prv = '0; vmask = '0; cur_k = 0; cyc = 0; rd = 0; visits = 0;
      order_ok = 1'b1; last_rdf = 1'b1;
      fork
         begin : monitor
            while (!done) begin
               @(posedge clk); #1;
               cur = ~oefifo_b;
               for (int j = 1; j <= 7; j++) sel_oh[j] = (sel == 3'(j));
               inv_ok = $onehot0(cur) && $onehot0(~renfifo_b) &&
                        ((~renfifo_b & oefifo_b) == 7'h00) &&
                        !(prv != 7'h00 && cur != 7'h00 && cur != prv) &&
                        (cur == 7'h00 || sel_oh == cur);
               check("enable_exclusion", 32'(inv_ok), 32'd1);
               if (prv != 7'h00 && cur != prv && rst_b) begin
                  if (kind[cur_k] == 0) check("words_read", 32'(rd), 32'(words[cur_k]));
                  else                  check("read_cycles", 32'(cyc), 32'(TOUT + 1));
               end
               if (cur != 7'h00 && cur != prv) begin
                  for (int j = 1; j <= 7; j++) if (cur[j]) begin
                     if (j <= cur_k) order_ok = 1'b0;
                     cur_k = j;
                  end
                  cyc = 0;
                  rd  = 0;
                  visits++;
                  vmask = vmask | cur;
               end
               if (cur != 7'h00) begin
                  cyc++;
                  if (renfifo_b != 7'h7F) rd++;
               end
               prv = cur;
               eof_det = (cur != 7'h00) &&
                         ((kind[cur_k] == 0 && renfifo_b != 7'h7F && rd == words[cur_k]) ||
                          (kind[cur_k] == 2 && cyc == TOUT + 1));
               case (rd_mode)
                  0:       rdffnxt = 1'b1;
                  1:       rdffnxt = ~last_rdf;
                  default: rdffnxt = last_rdf ? 1'($urandom_range(0, 1)) : 1'b1;
               endcase
               last_rdf = rdffnxt;
               if (pop) begin
                  if (exp_q.size() == 0) begin
                     check("pop_expected", 32'd0, 32'd1);
                  end else begin
                     e_mon = exp_q.pop_front();
                     check("toerr", 32'(toerr), 32'(e_mon.toerr));
                     check("wrdcnt", 32'(wrdcnt), 32'(e_mon.wrd));
                     check("visited_mask", 32'(vmask), 32'(e_mon.mask));
                     check("visit_count", 32'(visits), 32'($countones(e_mon.mask)));
                     check("ascending_order", 32'(order_ok), 32'd1);
                     check("busy_at_pop", 32'(busy), 32'd1);
                  end
               end
               if (!busy && !pop) begin
                  vmask = '0; visits = 0; cur_k = 0; order_ok = 1'b1;
               end
            end
         end
         begin : stimulus
            repeat (3) @(posedge clk);
            #1;
            check("rst_renfifo_b", 32'(renfifo_b), 32'h7F);
            check("rst_oefifo_b", 32'(oefifo_b), 32'h7F);
            check("rst_sel", 32'(sel), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_pop", 32'(pop), 32'd0);
            check("rst_toerr", 32'(toerr), 32'd0);
            check("rst_wrdcnt", 32'(wrdcnt), 32'd0);
            rst_b = 1'b1;

            set_all(0, 4);
            run_event(7'b0000101, 0, 1'b0);
            run_event(7'b0000000, 0, 1'b1);
            set_all(0, 3);
            kind[2] = 1;
            run_event(7'b0000010, 0, 1'b0);
            set_all(0, 5);
            run_event(7'b0100000, 1, 1'b1);
            kind[7] = 2;
            run_event(7'b1000000, 2, 1'b0);
            run_event(7'b1001011, 2, 1'b1);

            // asynchronous reset while FIFO4 is being read
            set_all(0, 5);
            for (int j = 1; j <= 7; j++) ffor_b[j] = 1'b0;
            rd_mode = 0;
            start   = 1'b1;
            davenbl = 7'b0001000;
            @(posedge clk); #1;
            start = 1'b0;
            for (int n = 0; n < 50 && renfifo_b[4] != 1'b0; n++) begin
               @(posedge clk); #1;
            end
            check("fifo4_reading", 32'(renfifo_b[4]), 32'd0);
            #1;
            rst_b = 1'b0;
            #1;
            check("arst_renfifo_b", 32'(renfifo_b), 32'h7F);
            check("arst_oefifo_b", 32'(oefifo_b), 32'h7F);
            check("arst_busy", 32'(busy), 32'd0);
            check("arst_pop", 32'(pop), 32'd0);
            check("arst_wrdcnt", 32'(wrdcnt), 32'd0);
            repeat (3) begin
               @(posedge clk); #1;
               check("no_pop_in_reset", 32'(pop), 32'd0);
            end
            rst_b      = 1'b1;
            last_wrd   = '0;
            last_toerr = '0;
            run_event(7'b0001000, 0, 1'b0);

            for (int t = 0; t < 25; t++) begin
               for (int j = 1; j <= 7; j++) begin
                  int r;
                  r = int'($urandom_range(0, 9));
                  kind[j]  = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
                  words[j] = int'($urandom_range(1, 5));
               end
               run_event(7'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
            repeat (2) @(posedge clk);
            done = 1'b1;
         end
      join
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fifo_rdout_sched.md
FIFO_RDOUT_SCHED -- requirements
Module: fifo_rdout_sched

Interface
REQ-001 Parameter TMR, default 0, triplication select passed to internal counter instances (0 = none).
REQ-002 Parameter TOUT, default 4095, maximum READ-state cycles per FIFO before abandon (12-bit range, 1..4095).
REQ-003 CLK  in  1  CMS clock; all logic rising-edge.
REQ-004 RST_B  in  1  asynchronous active-low reset.
REQ-005 START  in  1  one-cycle pulse: event ready for readout.
REQ-006 DAVENBL  in  7  [7:1] FIFOs holding data for this event; sampled on accepted START.
REQ-007 FFOR_B  in  7  [7:1] FIFO output-ready, active-low.
REQ-008 RDFFNXT  in  1  downstream accepts a word this cycle.
REQ-009 EOF_DET  in  1  end-of-frame word present on data bus from current FIFO.
REQ-010 RENFIFO_B  out  7  [7:1] FIFO read enables, active-low, registered.
REQ-011 OEFIFO_B  out  7  [7:1] FIFO output enables, active-low, registered.
REQ-012 SEL  out  3  index (1..7) of FIFO owning bus; 0 when none.
REQ-013 BUSY  out  1  high from accepted START until DONE.
REQ-014 POP  out  1  one-cycle pulse at event completion.
REQ-015 TOERR  out  7  [7:1] sticky timeout flags for current event.
REQ-016 WRDCNT  out  16  words read for current event.

Function
REQ-017 States: IDLE, SCAN, OE_SETUP, READ, GAP, DONE; all outputs registered.
REQ-018 IDLE: START accepted -> latch DAVENBL into pending mask, clear TOERR and WRDCNT, go SCAN next cycle.
REQ-019 START while not IDLE ignored; not queued.
REQ-020 SCAN: lowest set pending bit k selected, SEL=k, bit k cleared, go OE_SETUP; pending mask zero -> go DONE.
REQ-021 OE_SETUP: one cycle, OEFIFO_B[k]=0, all RENFIFO_B=1, go READ.
REQ-022 READ: OEFIFO_B[k]=0; RENFIFO_B[k]=0 in cycles where RDFFNXT=1 and FFOR_B[k]=0, else 1.
REQ-023 WRDCNT increments by 1 for each READ cycle with RENFIFO_B[k]=0; saturates at 0xFFFF.
REQ-024 READ exits to GAP on EOF_DET=1 (that cycle's read still counted if enabled).
REQ-025 Watchdog: 12-bit counter cleared on entry to READ, increments each READ cycle; reaching TOUT sets TOERR[k], exits to GAP.
REQ-026 EOF_DET and timeout same cycle: EOF wins, TOERR[k] not set.
REQ-027 GAP: one cycle, all OEFIFO_B and RENFIFO_B =1, SEL=0, go SCAN; guarantees no two OEFIFO_B low in same or adjacent cycles.
REQ-028 At most one OEFIFO_B bit and one RENFIFO_B bit low at any time; RENFIFO_B[k] low only while OEFIFO_B[k] low.
REQ-029 DONE: POP=1 one cycle, BUSY=0 on following cycle, go IDLE.
REQ-030 Latency START -> first OEFIFO_B low = 2 cycles; event with all DAVENBL zero: START -> POP = 2 cycles.
REQ-031 FFOR_B[k] high throughout READ: no reads, watchdog still runs, timeout path taken.
REQ-032 DAVENBL changes after START: no effect on current event.
REQ-033 TOERR and WRDCNT hold their values after DONE until next accepted START.

Reset
REQ-034 RST_B low: immediately state IDLE, RENFIFO_B=7'h7F, OEFIFO_B=7'h7F, SEL=0, BUSY=0, POP=0, TOERR=0, WRDCNT=0, pending mask=0, watchdog=0.
REQ-035 RST_B asserted mid-READ: enables released asynchronously, no POP generated; operation restarts only on new START after release.
REQ-036 Reset release synchronous to CLK; first START accepted on first rising edge with RST_B high.

Verification
REQ-037 DAVENBL=7'b0000101, FFOR_B=0, RDFFNXT=1, EOF after 4 words each -> FIFO1 then FIFO3 read, WRDCNT=8, one GAP cycle between, POP once, TOERR=0.
REQ-038 DAVENBL=0 -> POP 2 cycles after START, no OEFIFO_B/RENFIFO_B activity.
REQ-039 TOUT=16, FFOR_B[2]=1 with DAVENBL=7'b0000010 -> TOERR=7'b0000010 after 16 READ cycles, WRDCNT=0, POP issued.
REQ-040 RDFFNXT toggling 1/0 in READ -> RENFIFO_B[k] low only on RDFFNXT=1 cycles; WRDCNT equals count of those cycles up to EOF.
REQ-041 RST_B low during READ of FIFO4 -> all enables high same cycle, BUSY=0, no POP; subsequent START runs full event.
REQ-042 Second START during BUSY -> ignored; assertion checker confirms mutual exclusion of OEFIFO_B across all scenarios.
